// File: rtl/dpm_pkg.sv
// Shared definitions for the dual-port memory read/write side logic.
// Holds the reader FSM encoding, output buffer depth and default widths.
package dpm_pkg;

  localparam int DPM_ADDR_WIDTH = 4;
  localparam int DPM_DATA_WIDTH = 8;
  localparam int DPM_BUF_DEPTH  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

  // Circular pointer advance for the 3-entry buffer (0 -> 1 -> 2 -> 0).
  function automatic logic [1:0] buf_ptr_inc(input logic [1:0] p);
    return (p == 2'(DPM_BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/dpm_burst_reader_if.sv
// Memory read port plus output stream of the burst reader.
// master = reader side, slave = memory/stream-sink side.
interface dpm_burst_reader_if
  import dpm_pkg::*;
#(
  parameter int ADDR_WIDTH = DPM_ADDR_WIDTH,
  parameter int DATA_WIDTH = DPM_DATA_WIDTH
);
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic [DATA_WIDTH-1:0] mem_dout;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  modport master (
    output mem_rd_en, mem_rd_addr, m_valid, m_data, m_last,
    input  mem_dout, m_ready
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr, m_valid, m_data, m_last,
    output mem_dout, m_ready
  );
endinterface

// File: rtl/dpm_rd_skid.sv
// Three-entry circular output buffer for the burst reader.
// Each entry carries {last, data}; flush empties it without touching storage.
module dpm_rd_skid
  import dpm_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic [W-1:0] head_o,
  output logic [1:0]   occ_o
);
  logic [W-1:0] mem_q [DPM_BUF_DEPTH];
  logic [1:0]   wr_ptr_q, rd_ptr_q, occ_q, occ_d;

  for (genvar gi = 0; gi < DPM_BUF_DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem_q[gi] <= '0;
      end else if (push_i && !flush_i && wr_ptr_q == 2'(gi)) begin
        mem_q[gi] <= push_data_i;
      end
    end
  end

  always_comb begin
    occ_d = occ_q;
    if (push_i && !pop_i) begin
      occ_d = occ_q + 2'd1;
    end else if (pop_i && !push_i) begin
      occ_d = occ_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= buf_ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= buf_ptr_inc(rd_ptr_q);
      occ_q <= occ_d;
    end
  end

  assign valid_o = (occ_q != 2'd0);
  assign head_o  = mem_q[rd_ptr_q];
  assign occ_o   = occ_q;
endmodule

// File: rtl/dpm_burst_reader.sv
// Burst read controller: issues credit-limited memory reads and streams words out.
// Optional feature macro: DPM_RD_ABORT_EN (adds the abort input).
module dpm_burst_reader
  import dpm_pkg::*;
#(
  parameter int ADDR_WIDTH = DPM_ADDR_WIDTH,
  parameter int DATA_WIDTH = DPM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH-1:0] burst_len_m1,
  output logic                  busy,
  output logic                  done,
`ifdef DPM_RD_ABORT_EN
  input  logic                  abort,
`endif
  dpm_burst_reader_if.master    bus
);
  localparam logic [ADDR_WIDTH-1:0] ONE = 1;

  rd_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, rem_q, rem_d;
  logic                  inflight_q, inflight_last_q, done_q, done_d;
  logic                  issue, last_issue, push, pop, abort_act, buf_valid;
  logic [1:0]            occ;
  logic [DATA_WIDTH:0]   head;

`ifdef DPM_RD_ABORT_EN
  assign abort_act = abort && (state_q != ST_IDLE);
`else
  assign abort_act = 1'b0;
`endif

  // Credit counts buffered words plus the read still on its way from memory.
  assign issue      = (state_q == ST_READ) && !abort_act &&
                      (({1'b0, occ} + {2'b0, inflight_q}) < 3'(DPM_BUF_DEPTH));
  assign last_issue = issue && (rem_q == '0);
  assign push       = inflight_q && !abort_act;
  assign pop        = buf_valid && bus.m_ready && !abort_act;

  dpm_rd_skid #(.W(DATA_WIDTH + 1)) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (abort_act),
    .push_i     (push),
    .push_data_i({inflight_last_q, bus.mem_dout}),
    .pop_i      (pop),
    .valid_o    (buf_valid),
    .head_o     (head),
    .occ_o      (occ)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_READ;
          addr_d  = start_addr;
          rem_d   = burst_len_m1;
        end
      end
      ST_READ: begin
        if (issue) begin
          addr_d = addr_q + ONE;
          rem_d  = rem_q - ONE;
          if (rem_q == '0) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && head[DATA_WIDTH]) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort_act) begin
      state_d = ST_IDLE;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      rem_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      rem_q           <= rem_d;
      inflight_q      <= issue;
      inflight_last_q <= last_issue;
      done_q          <= done_d;
    end
  end

  assign busy            = (state_q != ST_IDLE);
  assign done            = done_q;
  assign bus.mem_rd_en   = issue;
  assign bus.mem_rd_addr = addr_q;
  assign bus.m_valid     = buf_valid && !abort_act;
  assign bus.m_data      = head[DATA_WIDTH-1:0];
  assign bus.m_last      = head[DATA_WIDTH];
endmodule

// File: tb/tb_dpm_burst_reader.sv
// Directed bench for dpm_burst_reader: table of bursts plus reset/abort sequences.
// Abort sequence is compiled in only when DPM_RD_ABORT_EN is defined.
module tb_dpm_burst_reader;
  import dpm_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] start_addr = '0;
  logic [3:0] burst_len_m1 = '0;
  logic       busy, done;
  logic       abort = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [16];

  dpm_burst_reader_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();

  dpm_burst_reader #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .start_addr  (start_addr),
    .burst_len_m1(burst_len_m1),
    .busy        (busy),
    .done        (done),
`ifdef DPM_RD_ABORT_EN
    .abort       (abort),
`endif
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // Memory read port: one-cycle registered read.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_dout <= mem[bus.mem_rd_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic rdy_pattern(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 4) == 0;
      default: return cyc >= 6;
    endcase
  endfunction

  typedef struct {
    logic [3:0] sa;
    logic [3:0] len;
    int         mode;
    int         spurious;
    logic [7:0] first;
    logic [7:0] last;
    int         n;
  } vec_t;

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_burst(input string tag, input logic [3:0] sa, input logic [3:0] len,
                           input int mode, input int spurious,
                           input logic [7:0] exp_first, input logic [7:0] exp_last,
                           input int exp_n);
    int cyc = 0, beats = 0, issued = 0, pending = 0, first_cyc = -1;
    logic [7:0] got_first = 8'h00, got_last_data = 8'h00, prev_data = 8'h00;
    logic prev_stall = 1'b0, prev_last = 1'b0, got_last = 1'b0;
    logic order_bad = 1'b0, last_bad = 1'b0, stable_bad = 1'b0;
    logic credit_bad = 1'b0, addr_bad = 1'b0;
    logic hs;
    start = 1'b1; start_addr = sa; burst_len_m1 = len; bus.m_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; start_addr = ~sa; burst_len_m1 = ~len;
    chk({tag, " busy_after_start"}, 32'(busy), 32'd1);
    chk({tag, " rd_en_after_start"}, 32'(bus.mem_rd_en), 32'd1);
    chk({tag, " rd_addr_first"}, 32'(bus.mem_rd_addr), 32'(sa));
    while (!got_last && cyc < 200) begin
      if (bus.m_valid && first_cyc < 0) first_cyc = cyc;
      if (prev_stall && (!bus.m_valid || bus.m_data !== prev_data || bus.m_last !== prev_last))
        stable_bad = 1'b1;
      if (bus.mem_rd_en) begin
        if (pending >= 3) credit_bad = 1'b1;
        if (bus.mem_rd_addr !== 4'(sa + 4'(issued))) addr_bad = 1'b1;
      end
      bus.m_ready = rdy_pattern(mode, cyc);
      hs = bus.m_valid && bus.m_ready;
      if (hs) begin
        if (beats == 0) got_first = bus.m_data;
        if (bus.m_data !== mem[4'(sa + 4'(beats))]) order_bad = 1'b1;
        if (bus.m_last !== (beats == exp_n - 1)) last_bad = 1'b1;
        if (bus.m_last) begin
          got_last = 1'b1;
          got_last_data = bus.m_data;
        end
        beats++;
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
      prev_last  = bus.m_last;
      pending    = pending + (bus.mem_rd_en ? 1 : 0) - (hs ? 1 : 0);
      if (bus.mem_rd_en) issued++;
      start = (cyc == spurious);
      start_addr = 4'(sa + 4'd7);
      burst_len_m1 = 4'd1;
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    chk({tag, " no_timeout"}, 32'(got_last), 32'd1);
    chk({tag, " first_valid_cycle"}, 32'(first_cyc), 32'd2);
    chk({tag, " first_data"}, 32'(got_first), 32'(exp_first));
    chk({tag, " last_data"}, 32'(got_last_data), 32'(exp_last));
    chk({tag, " beat_count"}, 32'(beats), 32'(exp_n));
    chk({tag, " issue_count"}, 32'(issued), 32'(exp_n));
    chk({tag, " data_order"}, 32'(order_bad), 32'd0);
    chk({tag, " last_flag"}, 32'(last_bad), 32'd0);
    chk({tag, " stall_stable"}, 32'(stable_bad), 32'd0);
    chk({tag, " credit_le3"}, 32'(credit_bad), 32'd0);
    chk({tag, " issue_addr"}, 32'(addr_bad), 32'd0);
    chk({tag, " done_pulse"}, 32'(done), 32'd1);
    chk({tag, " busy_low_at_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    chk({tag, " done_single"}, 32'(done), 32'd0);
    $display("burst %s sa=%0d len_m1=%0d mode=%0d beats=%0d issued=%0d", tag, sa, len, mode, beats, issued);
  endtask

  vec_t vecs [6];

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'(i + 8'h10);
    bus.m_ready = 1'b0;
    bus.mem_dout = 8'h00;

    vecs[0] = '{sa: 4'd4,  len: 4'd3,  mode: 0, spurious: -1, first: 8'h14, last: 8'h17, n: 4};
    vecs[1] = '{sa: 4'd14, len: 4'd3,  mode: 0, spurious: -1, first: 8'h1E, last: 8'h11, n: 4};
    vecs[2] = '{sa: 4'd0,  len: 4'd15, mode: 1, spurious: -1, first: 8'h10, last: 8'h1F, n: 16};
    vecs[3] = '{sa: 4'd9,  len: 4'd0,  mode: 1, spurious: -1, first: 8'h19, last: 8'h19, n: 1};
    vecs[4] = '{sa: 4'd5,  len: 4'd15, mode: 0, spurious: 4,  first: 8'h15, last: 8'h14, n: 16};
    vecs[5] = '{sa: 4'd15, len: 4'd6,  mode: 2, spurious: -1, first: 8'h1F, last: 8'h15, n: 7};

    repeat (2) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset rd_en", 32'(bus.mem_rd_en), 32'd0);
    chk("reset rd_addr", 32'(bus.mem_rd_addr), 32'd0);
    chk("reset m_valid", 32'(bus.m_valid), 32'd0);
    chk("reset m_data", 32'(bus.m_data), 32'd0);
    chk("reset m_last", 32'(bus.m_last), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    mem[2] = 8'hA5;
    run_burst("single_a5", 4'd2, 4'd0, 0, -1, 8'hA5, 8'hA5, 1);
    mem[2] = 8'h12;

    for (int v = 0; v < 6; v++) begin
      run_burst($sformatf("vec%0d", v), vecs[v].sa, vecs[v].len, vecs[v].mode,
                vecs[v].spurious, vecs[v].first, vecs[v].last, vecs[v].n);
    end

    // Reset mid-burst: outputs clear at once and no done follows.
    start = 1'b1; start_addr = 4'd0; burst_len_m1 = 4'd15; bus.m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst rd_en", 32'(bus.mem_rd_en), 32'd0);
    chk("midrst rd_addr", 32'(bus.mem_rd_addr), 32'd0);
    chk("midrst m_valid", 32'(bus.m_valid), 32'd0);
    chk("midrst m_data", 32'(bus.m_data), 32'd0);
    chk("midrst m_last", 32'(bus.m_last), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst no_done", 32'(done), 32'd0);
    chk("midrst idle", 32'(busy), 32'd0);
    $display("reset mid-burst sequence applied");
    run_burst("after_rst", 4'd3, 4'd15, 0, -1, 8'h13, 8'h12, 16);

`ifdef DPM_RD_ABORT_EN
    begin
      int beats = 0;
      int guard = 0;
      start = 1'b1; start_addr = 4'd0; burst_len_m1 = 4'd15; bus.m_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (beats < 3 && guard < 50) begin
        if (bus.m_valid) beats++;
        @(negedge clk);
        guard++;
      end
      chk("abort reached_beat3", 32'(beats), 32'd3);
      abort = 1'b1;
      #1;
      chk("abort m_valid_drop", 32'(bus.m_valid), 32'd0);
      chk("abort rd_en_drop", 32'(bus.mem_rd_en), 32'd0);
      @(negedge clk);
      abort = 1'b0;
      chk("abort done_pulse", 32'(done), 32'd1);
      chk("abort busy_low", 32'(busy), 32'd0);
      chk("abort m_valid_low", 32'(bus.m_valid), 32'd0);
      @(negedge clk);
      chk("abort done_single", 32'(done), 32'd0);
      chk("abort no_late_valid", 32'(bus.m_valid), 32'd0);
      $display("abort sequence applied after %0d beats", beats);
    end
    run_burst("after_abort", 4'd6, 4'd2, 0, -1, 8'h16, 8'h18, 3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
